baud_config_ctrl: RTL
=====================

BAUD_CONFIG_CTRL -- requirements
Module: baud_config_ctrl

Interface
REQ-001 The block SHALL have these parameters, one per line:
- DEFAULT_PERIOD, 12'd20, reset value of acq_period_o.
- DEFAULT_COMP, 8'hA5, reset value of bit_comp_o.
REQ-002 The block SHALL have these ports, one per line:
- clk, in, 1, system clock; one clock domain only.
- rst, in, 1, asynchronous reset, active-high.
- cfg_valid_i, in, 1, configuration request.
- cfg_ready_o, out, 1, block is idle and can accept a request.
- sysclk_hz_i, in, 32, system clock frequency in Hz.
- baud_i, in, 24, requested baud rate in bit/s.
- ovs_i, in, 5, oversampling factor; legal range 2..16.
- baud_tick_i, in, 1, one-clock BaudSig pulse from the baudrate generator.
- acq_period_o, out, 12, AcqPeriod value for the generator.
- bit_comp_o, out, 8, BitCompensation value for the generator: [7:4] is the round-up count, [3:0] is the round-down count.
- done_o, out, 1, one-clock pulse when the new configuration is in effect.
- err_o, out, 1, one-clock pulse when a request is rejected.

Function
REQ-003 A request SHALL be accepted only when cfg_valid_i and cfg_ready_o are both 1 on the same clock edge; inputs are sampled on that edge.
REQ-004 cfg_ready_o SHALL be 1 only in IDLE. A cfg_valid_i that arrives while busy SHALL be ignored.
REQ-005 The state machine SHALL have states IDLE, MUL, DIV1, DIV2, CHECK, WAIT_TICK.
- IDLE to MUL on accept.
- MUL to DIV1 after 1 cycle.
- DIV1 to DIV2 when the divider finishes.
- DIV2 to CHECK when the divider finishes.
- CHECK to WAIT_TICK on success; CHECK to IDLE on error.
- WAIT_TICK to IDLE when baud_tick_i=1.
REQ-006 MUL SHALL compute N = baud_i * ovs_i as a 29-bit result.
REQ-007 DIV1 SHALL compute Q = floor(sysclk_hz_i / N) and R = remainder, with 32-bit operands and 32 iterations.
REQ-008 DIV2 SHALL compute U = floor((2R + baud_i) / (2*baud_i)), which is round-half-up of R/baud_i. The range of U is 0..ovs_i.
REQ-009 Case U < ovs_i: CHECK SHALL set P = Q-1 and bit_comp = {U[3:0], (ovs_i-1-U)[3:0]}.
REQ-010 Case U == ovs_i: CHECK SHALL set P = Q and bit_comp = {4'd0, (ovs_i-1)[3:0]}.
REQ-011 CHECK SHALL raise err_o, leave outputs unchanged and return to IDLE if any of these hold:
- baud_i == 0;
- ovs_i < 2 or ovs_i > 16;
- Q < 2;
- P > 4095.
REQ-012 On success, acq_period_o and bit_comp_o SHALL update in the CHECK cycle and SHALL then hold stable. The generator latches them at its next baud boundary.
REQ-013 done_o SHALL pulse in the cycle after the first baud_tick_i seen in WAIT_TICK. A baud_tick_i that coincides with the CHECK cycle SHALL NOT count.
REQ-014 Latency from accept to CHECK SHALL be fixed at 1 + 33 + 33 cycles, with the divider including a load cycle. The count SHALL be deterministic and independent of operand values.
REQ-015 err_o and done_o SHALL never be asserted in the same cycle.

Reset
REQ-016 On rst=1, asynchronously:
- state = IDLE;
- cfg_ready_o = 1;
- acq_period_o = DEFAULT_PERIOD;
- bit_comp_o = DEFAULT_COMP;
- done_o = 0, err_o = 0;
- all divider registers cleared.
REQ-017 Reset in the middle of an operation SHALL abandon the computation without pulsing done_o or err_o. Outputs return to their defaults.

Structure
REQ-018 A shared package SHALL hold:
- the state encoding;
- DEFAULT_PERIOD and DEFAULT_COMP;
- the OVS_MIN=2 and OVS_MAX=16 limits;
- the ACQ_PERIOD_MAX=4095 limit.
REQ-019 A single sub-module, serial_divider, SHALL implement a 32-bit restoring divider:
- start/busy/done handshake, one quotient bit per cycle;
- instantiated once and reused for both DIV1 and DIV2.

Verification
REQ-020 Test: sysclk 40,000,000, baud 115200, ovs 16. Expect acq_period_o=20 and bit_comp_o=8'hB4. A bit period of 347 clocks SHALL be measured on the generator.
REQ-021 Test: sysclk 50,000,000, baud 9600, ovs 16. Expect acq_period_o=12'h144 and bit_comp_o=8'h87.
REQ-022 Test: sysclk 6,390,000, baud 100,000, ovs 16. Expect acq_period_o=3 and bit_comp_o=8'h0F (the U==ovs case).
REQ-023 Error cases, each giving an err_o pulse with outputs unchanged at 20 / 8'hA5:
- baud 0;
- ovs 1 or 17;
- sysclk 1,000,000, baud 115200, ovs 16 (Q=0).
REQ-024 Handshake and reset cases:
- cfg_valid_i held during busy gives no second accept.
- done_o follows exactly one cycle after the first baud_tick_i in WAIT_TICK.
- rst during DIV1 returns outputs to defaults with no done_o and no err_o.

Source files
------------

// File: rtl/baud_config_ctrl_pkg.sv
// Shared definitions for the baud configuration controller: FSM state
// encoding, reset defaults, legal limits and the request payload.
package baud_config_ctrl_pkg;

  localparam int unsigned SYSCLK_W = 32;
  localparam int unsigned BAUD_W   = 24;
  localparam int unsigned OVS_W    = 5;
  localparam int unsigned PERIOD_W = 12;
  localparam int unsigned COMP_W   = 8;
  localparam int unsigned DIV_W    = 32;
  localparam int unsigned CNT_W    = 6;
  localparam int unsigned MUL_W    = BAUD_W + OVS_W;

  localparam logic [PERIOD_W-1:0] DEFAULT_PERIOD = 12'd20;
  localparam logic [COMP_W-1:0]   DEFAULT_COMP   = 8'hA5;

  localparam logic [OVS_W-1:0]    OVS_MIN        = 5'd2;
  localparam logic [OVS_W-1:0]    OVS_MAX        = 5'd16;
  localparam logic [PERIOD_W-1:0] ACQ_PERIOD_MAX = 12'd4095;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV1,
    ST_DIV2,
    ST_CHECK,
    ST_WAIT_TICK
  } state_e;

  // Request operands captured at accept time.
  typedef struct packed {
    logic [SYSCLK_W-1:0] sysclk;
    logic [BAUD_W-1:0]   baud;
    logic [OVS_W-1:0]    ovs;
  } cfg_req_t;

endpackage

// File: rtl/baud_config_ctrl_serial_divider.sv
// 32-bit restoring divider, one quotient bit per clock.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start_i             load operands (takes effect on this edge)
//   dividend_i/divisor_i operands sampled with start_i
//   busy_o              iterating
//   done_o              one-cycle pulse with the last quotient bit
//   quotient_o/remainder_o results, held until the next start
// Timing: load edge + 32 iteration edges; done_o is high after the 32nd.
module serial_divider
  import baud_config_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [DIV_W-1:0] dividend_i,
  input  logic [DIV_W-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [DIV_W-1:0] quotient_o,
  output logic [DIV_W-1:0] remainder_o
);

  logic [DIV_W-1:0] rem_q, rem_d;
  logic [DIV_W-1:0] quo_q, quo_d;
  logic [DIV_W-1:0] dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [DIV_W:0]   partial_c;
  logic [DIV_W:0]   diff_c;

  // Shift the next dividend bit into the partial remainder and trial-subtract.
  assign partial_c = {rem_q, quo_q[DIV_W-1]};
  assign diff_c    = partial_c - {1'b0, dvs_q};

  always_comb begin
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (start_i) begin
      rem_d  = '0;
      quo_d  = dividend_i;
      dvs_d  = divisor_i;
      cnt_d  = CNT_W'(DIV_W);
      busy_d = 1'b1;
    end else if (busy_q) begin
      // Borrow out of the trial subtraction means restore.
      if (!diff_c[DIV_W]) begin
        rem_d = diff_c[DIV_W-1:0];
        quo_d = {quo_q[DIV_W-2:0], 1'b1};
      end else begin
        rem_d = partial_c[DIV_W-1:0];
        quo_d = {quo_q[DIV_W-2:0], 1'b0};
      end
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

endmodule

// File: rtl/baud_config_ctrl.sv
// Baud configuration controller: turns (sysclk, baud, oversampling) into
// the AcqPeriod / BitCompensation pair of a fractional baudrate generator.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   cfg_valid_i       request; accepted when cfg_ready_o is high
//   cfg_ready_o       idle, can accept a request
//   sysclk_hz_i       system clock in Hz
//   baud_i            baud rate in bit/s
//   ovs_i             oversampling factor (2..16)
//   baud_tick_i       BaudSig pulse from the generator
//   acq_period_o      AcqPeriod for the generator
//   bit_comp_o        {round-up count, round-down count}
//   done_o            new configuration in effect (one-cycle pulse)
//   err_o             request rejected (one-cycle pulse)
// Flow: N = baud*ovs; Q,R = sysclk / N; U = round(R / baud); then
// P = Q-1 with U long sub-bits, or P = Q when U rounds up to ovs.
module baud_config_ctrl #(
  parameter logic [11:0] DEFAULT_PERIOD = baud_config_ctrl_pkg::DEFAULT_PERIOD,
  parameter logic [7:0]  DEFAULT_COMP   = baud_config_ctrl_pkg::DEFAULT_COMP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_valid_i,
  output logic        cfg_ready_o,
  input  logic [31:0] sysclk_hz_i,
  input  logic [23:0] baud_i,
  input  logic [4:0]  ovs_i,
  input  logic        baud_tick_i,
  output logic [11:0] acq_period_o,
  output logic [7:0]  bit_comp_o,
  output logic        done_o,
  output logic        err_o
);

  import baud_config_ctrl_pkg::*;

  state_e              state_q, state_d;
  cfg_req_t            req_q, req_d;
  logic [DIV_W-1:0]    q1_q, q1_d;
  logic [PERIOD_W-1:0] acq_q, acq_d;
  logic [COMP_W-1:0]   comp_q, comp_d;
  logic                ready_q, ready_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic [MUL_W-1:0]    n_c;
  logic                div_start_c;
  logic [DIV_W-1:0]    div_dvd_c;
  logic [DIV_W-1:0]    div_dvs_c;
  logic                div_busy;
  logic                div_done;
  logic [DIV_W-1:0]    div_quo;
  logic [DIV_W-1:0]    div_rem;

  logic                u_lt_ovs_c;
  logic [DIV_W-1:0]    p_c;
  logic [3:0]          comp_hi_c;
  logic [3:0]          comp_lo_c;
  logic                reject_c;

  serial_divider u_div (
    .clk         (clk),
    .rst         (rst),
    .start_i     (div_start_c),
    .dividend_i  (div_dvd_c),
    .divisor_i   (div_dvs_c),
    .busy_o      (div_busy),
    .done_o      (div_done),
    .quotient_o  (div_quo),
    .remainder_o (div_rem)
  );

  // Full-width product, no overflow possible.
  assign n_c = MUL_W'(req_q.baud) * MUL_W'(req_q.ovs);

  // In CHECK the divider still holds U from the second division.
  assign u_lt_ovs_c = div_quo < DIV_W'(req_q.ovs);
  assign p_c        = u_lt_ovs_c ? (q1_q - DIV_W'(1)) : q1_q;
  assign comp_hi_c  = u_lt_ovs_c ? div_quo[3:0] : 4'd0;
  assign comp_lo_c  = u_lt_ovs_c ? 4'(req_q.ovs - 5'd1 - div_quo[4:0])
                                 : 4'(req_q.ovs - 5'd1);
  assign reject_c   = (req_q.baud == '0)
                   || (req_q.ovs < OVS_MIN)
                   || (req_q.ovs > OVS_MAX)
                   || (q1_q < DIV_W'(2))
                   || (p_c > DIV_W'(ACQ_PERIOD_MAX));

  // Next-state, divider sequencing and output updates.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    q1_d        = q1_q;
    acq_d       = acq_q;
    comp_d      = comp_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    div_start_c = 1'b0;
    div_dvd_c   = req_q.sysclk;
    div_dvs_c   = DIV_W'(n_c);

    unique case (state_q)
      ST_IDLE: begin
        if (cfg_valid_i) begin
          req_d.sysclk = sysclk_hz_i;
          req_d.baud   = baud_i;
          req_d.ovs    = ovs_i;
          state_d      = ST_MUL;
        end
      end
      ST_MUL: begin
        if (!div_busy) begin
          div_start_c = 1'b1;
          state_d     = ST_DIV1;
        end
      end
      ST_DIV1: begin
        // Second division is (2R + baud) / (2*baud): round-half-up of R/baud.
        div_dvd_c = (div_rem << 1) + DIV_W'(req_q.baud);
        div_dvs_c = DIV_W'(req_q.baud) << 1;
        if (div_done) begin
          q1_d        = div_quo;
          div_start_c = 1'b1;
          state_d     = ST_DIV2;
        end
      end
      ST_DIV2: begin
        if (div_done) begin
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (reject_c) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          acq_d   = p_c[PERIOD_W-1:0];
          comp_d  = {comp_hi_c, comp_lo_c};
          state_d = ST_WAIT_TICK;
        end
      end
      ST_WAIT_TICK: begin
        if (baud_tick_i) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      q1_q    <= '0;
      acq_q   <= DEFAULT_PERIOD;
      comp_q  <= DEFAULT_COMP;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      q1_q    <= q1_d;
      acq_q   <= acq_d;
      comp_q  <= comp_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign cfg_ready_o  = ready_q;
  assign acq_period_o = acq_q;
  assign bit_comp_o   = comp_q;
  assign done_o       = done_q;
  assign err_o        = err_q;

endmodule
